// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared types and constants for the instruction fetch unit
package instr_fetch_pkg;

   localparam int INSTR_W  = 9;
   localparam int PC_W_DEF = 10;

   typedef logic [PC_W_DEF-1:0] pc_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      RUN    = 2'd2,
      HALTED = 2'd3
   } fetch_state_e;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - saturating active-cycle and transfer counters for instr_fetch
module fetch_perf_cnt
   import instr_fetch_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        clear,
   input  logic        active,
   input  logic        xfer,
   output logic [31:0] Cycle_cnt,
   output logic [31:0] Instr_cnt
);

   always_ff @(posedge Clk) begin
      if (!Reset_n || clear) begin
         Cycle_cnt <= '0;
         Instr_cnt <= '0;
      end else begin
         if (active) Cycle_cnt <= sat_inc(Cycle_cnt);
         if (xfer)   Instr_cnt <= sat_inc(Instr_cnt);
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC owner and imem driver feeding decode over valid/ready
// FETCH_PERF_EN adds the Cycle_cnt/Instr_cnt performance counter outputs.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0
)(
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               Start,
   output logic               Imem_en,
   output logic [PC_W-1:0]    Imem_addr,
   input  logic [INSTR_W-1:0] Imem_data,
   output logic [INSTR_W-1:0] Instruction,
   output logic               Instr_valid,
   input  logic               Instr_ready,
   output logic [PC_W-1:0]    Instr_pc,
   input  logic               Branch_taken,
   input  logic [PC_W-1:0]    Branch_target,
   input  logic               Halt,
   output logic               Done
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        Cycle_cnt,
   output logic [31:0]        Instr_cnt
`endif
);

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   fetch_state_e        state;
   logic [PC_W-1:0]     pc;
   logic [PC_W-1:0]     pend_pc;
   logic                pend;
   logic                hold_vld;
   logic [INSTR_W-1:0]  hold_data;

   logic                xfer;
   logic                stop;
   logic                redirect;
   logic                room;
   logic                avail;
   logic [INSTR_W-1:0]  word;
   logic                launch;

   assign xfer     = Instr_valid & Instr_ready;
   assign stop     = xfer & Halt;
   assign redirect = xfer & Branch_taken & ~Halt;
   assign room     = ~Instr_valid | Instr_ready;
   // A fetched word waits either on the imem output (issued last cycle) or in
   // the hold register, which captures it when decode stalls on arrival.
   assign avail    = pend | hold_vld;
   assign word     = hold_vld ? hold_data : Imem_data;
   assign launch   = ((state == IDLE) || (state == HALTED)) && Start;

   assign Imem_en   = (state == FILL) || ((state == RUN) && room && !stop);
   assign Imem_addr = redirect ? Branch_target : pc;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         pend_pc     <= '0;
         pend        <= 1'b0;
         hold_vld    <= 1'b0;
         hold_data   <= '0;
         Instruction <= '0;
         Instr_valid <= 1'b0;
         Instr_pc    <= '0;
         Done        <= 1'b0;
      end else begin
         case (state)
            IDLE, HALTED: begin
               if (Start) begin
                  state <= FILL;
                  pc    <= RESET_PC;
                  Done  <= 1'b0;
               end
            end
            FILL: begin
               pend    <= 1'b1;
               pend_pc <= pc;
               pc      <= pc + PC_ONE;
               state   <= RUN;
            end
            RUN: begin
               if (stop) begin
                  state       <= HALTED;
                  Instr_valid <= 1'b0;
                  Done        <= 1'b1;
                  pend        <= 1'b0;
                  hold_vld    <= 1'b0;
               end else if (redirect) begin
                  // Sequential word in flight is dropped; the target was fetched this cycle.
                  Instr_valid <= 1'b0;
                  pend        <= 1'b1;
                  pend_pc     <= Branch_target;
                  pc          <= Branch_target + PC_ONE;
                  hold_vld    <= 1'b0;
               end else if (room) begin
                  Instr_valid <= avail;
                  if (avail) begin
                     Instruction <= word;
                     Instr_pc    <= pend_pc;
                  end
                  pend     <= 1'b1;
                  pend_pc  <= pc;
                  pc       <= pc + PC_ONE;
                  hold_vld <= 1'b0;
               end else begin
                  pend <= 1'b0;
                  if (pend) begin
                     hold_vld  <= 1'b1;
                     hold_data <= Imem_data;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   fetch_perf_cnt u_perf (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .clear     (launch),
      .active    ((state == FILL) || (state == RUN)),
      .xfer      (xfer),
      .Cycle_cnt (Cycle_cnt),
      .Instr_cnt (Instr_cnt)
   );
`else
   logic unused_launch;
   assign unused_launch = launch;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch against a presented-PC model
module tb_instr_fetch;
   import instr_fetch_pkg::*;

   logic               Clk = 1'b0;
   logic               Reset_n, Start, Imem_en, Instr_valid, Instr_ready;
   logic               Branch_taken, Halt, Done;
   pc_t                Imem_addr, Instr_pc, Branch_target;
   logic [INSTR_W-1:0] Imem_data = '0;
   logic [INSTR_W-1:0] Instruction;
`ifdef FETCH_PERF_EN
   logic [31:0]        Cycle_cnt, Instr_cnt;
`endif

   always #5 Clk = ~Clk;

   instr_fetch #(.PC_W(10), .RESET_PC(10'd0)) dut (
      .Clk           (Clk),
      .Reset_n       (Reset_n),
      .Start         (Start),
      .Imem_en       (Imem_en),
      .Imem_addr     (Imem_addr),
      .Imem_data     (Imem_data),
      .Instruction   (Instruction),
      .Instr_valid   (Instr_valid),
      .Instr_ready   (Instr_ready),
      .Instr_pc      (Instr_pc),
      .Branch_taken  (Branch_taken),
      .Branch_target (Branch_target),
      .Halt          (Halt),
      .Done          (Done)
`ifdef FETCH_PERF_EN
      ,
      .Cycle_cnt     (Cycle_cnt),
      .Instr_cnt     (Instr_cnt)
`endif
   );

   // Synchronous imem; output is scrambled when not enabled so stale data is never trusted.
   logic [INSTR_W-1:0] mem [0:1023];
   always @(posedge Clk) begin
      if (Imem_en) Imem_data <= mem[Imem_addr];
      else         Imem_data <= 9'h1AA;
   end

   int checks = 0;
   int failures = 0;
   logic chk_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: which PC decode should see, and when, from the handshake rules alone.
   logic        m_busy = 0, m_valid = 0, m_done = 0;
   int          m_wait = 0;
   pc_t         m_pc = '0, m_next = '0;
   logic [31:0] m_cyc = 0, m_icnt = 0;
   logic        m_xfer;

   always @(posedge Clk) begin
      if (!Reset_n) begin
         m_busy = 0; m_valid = 0; m_done = 0; m_wait = 0; m_pc = '0; m_cyc = 0; m_icnt = 0;
      end else if (!m_busy) begin
         if (Start) begin
            m_busy = 1; m_done = 0; m_valid = 0; m_wait = 2; m_next = '0; m_cyc = 0; m_icnt = 0;
         end
      end else begin
         m_xfer = m_valid && Instr_ready;
         if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
         if (m_xfer && m_icnt != 32'hFFFF_FFFF) m_icnt = m_icnt + 1;
         if (m_xfer && Halt) begin
            m_busy = 0; m_done = 1; m_valid = 0; m_wait = 0;
         end else begin
            if (m_xfer) begin
               m_valid = 0;
               m_next  = Branch_taken ? Branch_target : pc_t'(m_pc + 10'd1);
               m_wait  = Branch_taken ? 2 : 1;
            end
            if (!m_valid && m_wait > 0) begin
               m_wait = m_wait - 1;
               if (m_wait == 0) begin
                  m_valid = 1;
                  m_pc    = m_next;
               end
            end
         end
      end
   end

   logic watch8 = 0, seen8 = 0, watch_rd = 0, seen_rd = 0;

   always @(negedge Clk) begin
      if (chk_on) begin
         chk("valid", Instr_valid, m_valid);
         chk("done", Done, m_done);
         if (m_valid) begin
            chk("instr_pc", Instr_pc, m_pc);
            chk("instruction", Instruction, mem[m_pc]);
         end
         if (!m_busy || (m_valid && !Instr_ready))
            chk("imem_en_quiet", Imem_en, 1'b0);
`ifdef FETCH_PERF_EN
         chk("cycle_cnt", Cycle_cnt, m_cyc);
         chk("instr_cnt", Instr_cnt, m_icnt);
`endif
         if (watch8 && Instr_valid && Instr_pc == 10'd8) seen8 = 1;
         if (watch_rd && Imem_en && Imem_addr == 10'h123) seen_rd = 1;
      end
   end

   task automatic step(input logic rn, input logic st, input logic rd, input logic br,
                       input pc_t tg, input logic hl);
      Reset_n = rn; Start = st; Instr_ready = rd; Branch_taken = br; Branch_target = tg; Halt = hl;
      @(posedge Clk);
      #1;
   endtask

   task automatic go(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 1, 0, '0, 0);
   endtask

   pc_t wrap_exp [4];

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 9'((i * 37 + 11) % 512);
      mem[0] = 9'h001; mem[1] = 9'h080; mem[2] = 9'h102; mem[3] = 9'h181;
      wrap_exp[0] = 10'h3FE; wrap_exp[1] = 10'h3FF; wrap_exp[2] = 10'h000; wrap_exp[3] = 10'h001;

      step(0, 0, 0, 0, '0, 0);
      step(0, 0, 0, 0, '0, 0);
      chk_on = 1;
      chk("rst_valid", Instr_valid, 0);
      chk("rst_done", Done, 0);
      chk("rst_imem_en", Imem_en, 0);
      chk("rst_pc", Instr_pc, 0);
      chk("rst_instr", Instruction, 0);

      // Linear run from reset PC, halt on the 4th transfer
      step(1, 1, 1, 0, '0, 0);
      step(1, 0, 1, 0, '0, 0);
      chk("t1_not_yet_valid", Instr_valid, 0);
      step(1, 0, 1, 0, '0, 0);
      chk("t1_first_valid", Instr_valid, 1);
      chk("t1_i0", Instruction, 9'h001);
      go(1); chk("t1_i1", Instruction, 9'h080);
      go(1); chk("t1_i2", Instruction, 9'h102);
      go(1); chk("t1_i3", Instruction, 9'h181);
      step(1, 0, 1, 0, '0, 1);
      chk("t1_done", Done, 1);
      chk("t1_valid_off", Instr_valid, 0);

      // Stall at PC 5, then taken branch at PC 7
      step(1, 1, 1, 0, '0, 0);
      go(2);
      go(5);
      chk("t2_at5", Instr_pc, 10'd5);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0, '0, 0);
         chk("t2_stall_pc", Instr_pc, 10'd5);
         chk("t2_stall_en", Imem_en, 0);
      end
      go(1);
      chk("t2_resume_pc", Instr_pc, 10'd6);
      go(1);
      watch8 = 1;
      step(1, 0, 1, 1, 10'h040, 0);
      chk("t3_bubble", Instr_valid, 0);
      go(1);
      chk("t3_target_valid", Instr_valid, 1);
      chk("t3_target_pc", Instr_pc, 10'h040);
      watch8 = 0;
      chk("t3_pc8_skipped", seen8, 0);

      // Halt and branch on the same transfer: halt wins
      watch_rd = 1;
      step(1, 0, 1, 1, 10'h123, 1);
      chk("t4_done", Done, 1);
      go(2);
      chk("t4_quiet", Imem_en, 0);
      watch_rd = 0;
      chk("t4_no_redirect", seen_rd, 0);
      step(1, 1, 1, 0, '0, 0);
      go(2);
      chk("t4_restart_pc", Instr_pc, 10'd0);
      chk("t4_restart_instr", Instruction, 9'h001);

      // PC wrap at the top of the address space, then reset mid-run
      step(1, 0, 1, 1, 10'h3FE, 0);
      for (int i = 0; i < 4; i++) begin
         go(1);
         chk("t5_wrap_pc", Instr_pc, wrap_exp[i]);
      end
      step(0, 0, 1, 0, '0, 0);
      chk("t5_rst_valid", Instr_valid, 0);
      chk("t5_rst_done", Done, 0);
      chk("t5_rst_en", Imem_en, 0);
      step(1, 0, 1, 0, '0, 0);
      chk("t5_idle_en", Imem_en, 0);

      // Ten transfers with a 2-cycle stall, halt on the tenth
      step(1, 1, 1, 0, '0, 0);
      go(2);
      go(4);
      step(1, 0, 0, 0, '0, 0);
      step(1, 0, 0, 0, '0, 0);
      go(5);
      chk("t6_last_pc", Instr_pc, 10'd9);
      step(1, 0, 1, 0, '0, 1);
      chk("t6_done", Done, 1);
`ifdef FETCH_PERF_EN
      chk("t6_instr_cnt", Instr_cnt, 32'd10);
      chk("t6_cycle_cnt", Cycle_cnt, 32'd14);
      go(3);
      chk("t6_frozen_cycle", Cycle_cnt, 32'd14);
`else
      go(3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
